// File: rtl/cs_addr_seq.sv
// Control-store next-address sequencer: INC/JUMP/BRANCH/CALL/RET with a small
// return-address stack, stall input and a sticky overflow/underflow flag.
module cs_addr_seq #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ACK,
    input  logic [2:0]        OP,
    input  logic [ADDR_W-1:0] TARGET,
    input  logic              COND,
    output logic [ADDR_W-1:0] OUT,
    output logic [4:0]        LEVEL,
    output logic              STACK_EMPTY,
    output logic              STACK_FULL,
    output logic              ERR
);

    localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_L = 5'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_INC    = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    logic [ADDR_W-1:0] out_q, out_d, inc_addr;
    logic [4:0]        level_q, level_d;
    logic              err_q, err_d;
    logic              push_en;
    logic              stk_empty, stk_full;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    assign inc_addr  = out_q + ADDR_W'(1);
    assign stk_empty = (level_q == 5'd0);
    assign stk_full  = (level_q == DEPTH_L);
    assign push_idx  = level_q[IDX_W-1:0];
    assign top_idx   = IDX_W'(level_q - 5'd1);

    always_comb begin
        out_d   = out_q;
        level_d = level_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (!ACK) begin
            case (OP)
                OP_JUMP:   out_d = TARGET;
                OP_BRANCH: out_d = COND ? TARGET : inc_addr;
                OP_CALL: begin
                    if (!stk_full) begin
                        push_en = 1'b1;
                        level_d = level_q + 5'd1;
                        out_d   = TARGET;
                    end else begin
                        out_d = inc_addr;
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!stk_empty) begin
                        out_d   = stack_q[top_idx];
                        level_d = level_q - 5'd1;
                    end else begin
                        out_d = inc_addr;
                        err_d = 1'b1;
                    end
                end
                default:   out_d = inc_addr;  // INC and reserved opcodes
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_q   <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset: LEVEL alone decides which entries are valid.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[push_idx] <= inc_addr;
        end
    end

    assign OUT         = out_q;
    assign LEVEL       = level_q;
    assign STACK_EMPTY = stk_empty;
    assign STACK_FULL  = stk_full;
    assign ERR         = err_q;

endmodule

// File: tb/tb_cs_addr_seq.sv
// Self-checking bench for cs_addr_seq: directed scenarios plus randomized ops
// compared against a queue-based reference model.
module tb_cs_addr_seq;

    localparam int unsigned AW = 11;
    localparam int unsigned SD = 4;
    localparam int unsigned VW = AW + 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          ACK = 1'b1;
    logic [2:0]    OP = 3'd0;
    logic [AW-1:0] TARGET = '0;
    logic          COND = 1'b0;
    logic [AW-1:0] OUT;
    logic [4:0]    LEVEL;
    logic          STACK_EMPTY, STACK_FULL, ERR;

    int checks = 0;
    int errors = 0;

    int unsigned m_out = 0;
    int unsigned m_stk[$];
    bit          m_err = 1'b0;

    cs_addr_seq #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .CLK(CLK), .RESET(RESET), .ACK(ACK), .OP(OP), .TARGET(TARGET), .COND(COND),
        .OUT(OUT), .LEVEL(LEVEL), .STACK_EMPTY(STACK_EMPTY), .STACK_FULL(STACK_FULL), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {OUT, LEVEL, STACK_EMPTY, STACK_FULL, ERR};

    function automatic logic [VW-1:0] mk(input int unsigned o, input int unsigned lvl, input bit e);
        logic [AW-1:0] oa = AW'(o);
        logic [4:0]    la = 5'(lvl);
        return {oa, la, (lvl == 0), (lvl == SD), e};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return mk(m_out, m_stk.size(), m_err);
    endfunction

    task automatic model_step(input bit ack, input int op, input int unsigned tgt, input bit cond);
        int unsigned inc = (m_out + 1) % (1 << AW);
        if (ack) return;
        case (op)
            1: m_out = tgt;
            2: m_out = cond ? tgt : inc;
            3: if (m_stk.size() < SD) begin m_stk.push_back(inc); m_out = tgt; end
               else begin m_out = inc; m_err = 1'b1; end
            4: if (m_stk.size() > 0) m_out = m_stk.pop_back();
               else begin m_out = inc; m_err = 1'b1; end
            default: m_out = inc;
        endcase
    endtask

    task automatic drive(input bit ack, input int op, input int unsigned tgt, input bit cond);
        ACK = ack; OP = 3'(op); TARGET = AW'(tgt); COND = cond;
        @(posedge CLK);
        model_step(ack, op, tgt, cond);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        m_out = 0; m_stk.delete(); m_err = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; ACK = 1'b0; OP = 3'd0;
        #12;
        checks++;
        if (dut_vec !== mk(0, 0, 0)) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, mk(0, 0, 0));
        end
        RESET = 1'b0;
    endtask

    task automatic test_inc();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0);
            checks++;
            if (dut_vec !== mk(i, 0, 0)) begin
                errors++; $display("FAIL inc_step%0d: got %h expected %h", i, dut_vec, mk(i, 0, 0));
            end
        end
        drive(0, 5, 0, 0);
        checks++;
        if (dut_vec !== mk(6, 0, 0)) begin
            errors++; $display("FAIL reserved_op: got %h expected %h", dut_vec, mk(6, 0, 0));
        end
    endtask

    task automatic test_wrap();
        drive(0, 1, 'h7FF, 0);
        drive(0, 0, 0, 0);
        checks++;
        if (dut_vec !== mk(0, 0, 0)) begin
            errors++; $display("FAIL wrap_inc: got %h expected %h", dut_vec, mk(0, 0, 0));
        end
        drive(0, 1, 'h7FF, 0);
        drive(0, 2, 'h123, 0);
        checks++;
        if (dut_vec !== mk(0, 0, 0)) begin
            errors++; $display("FAIL wrap_branch: got %h expected %h", dut_vec, mk(0, 0, 0));
        end
        drive(0, 2, 'h123, 1);
        checks++;
        if (dut_vec !== mk('h123, 0, 0)) begin
            errors++; $display("FAIL branch_taken: got %h expected %h", dut_vec, mk('h123, 0, 0));
        end
    endtask

    task automatic test_stall();
        drive(0, 1, 'h010, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 'h100, 0);
            checks++;
            if (dut_vec !== mk('h010, 0, 0)) begin
                errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, dut_vec, mk('h010, 0, 0));
            end
        end
        drive(0, 1, 'h100, 0);
        checks++;
        if (dut_vec !== mk('h100, 0, 0)) begin
            errors++; $display("FAIL stall_release: got %h expected %h", dut_vec, mk('h100, 0, 0));
        end
    endtask

    task automatic test_call_ret();
        int unsigned ops[4]  = '{3, 3, 4, 4};
        int unsigned tgts[4] = '{'h200, 'h300, 0, 0};
        int unsigned eo[4]   = '{'h200, 'h300, 'h201, 'h021};
        int unsigned el[4]   = '{1, 2, 1, 0};
        do_reset();
        drive(0, 1, 'h020, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, ops[i], tgts[i], 0);
            checks++;
            if (dut_vec !== mk(eo[i], el[i], 0)) begin
                errors++; $display("FAIL call_ret%0d: got %h expected %h", i, dut_vec, mk(eo[i], el[i], 0));
            end
        end
    endtask

    task automatic test_overflow();
        int unsigned eo[6] = '{'h401, 'h301, 'h201, 'h101, 'h001, 'h002};
        int unsigned el[6] = '{4, 3, 2, 1, 0, 0};
        do_reset();
        for (int i = 1; i <= 4; i++) drive(0, 3, i * 'h100, 0);
        checks++;
        if (dut_vec !== mk('h400, 4, 0)) begin
            errors++; $display("FAIL stack_full: got %h expected %h", dut_vec, mk('h400, 4, 0));
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, (i == 0) ? 3 : 4, 'h500, 0);
            checks++;
            if (dut_vec !== mk(eo[i], el[i], 1)) begin
                errors++; $display("FAIL overflow_seq%0d: got %h expected %h", i, dut_vec, mk(eo[i], el[i], 1));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) drive(0, 3, i * 'h40, 0);
        checks++;
        if (dut_vec !== mk('hC0, 3, 0)) begin
            errors++; $display("FAIL pre_reset_level: got %h expected %h", dut_vec, mk('hC0, 3, 0));
        end
        ACK = 1'b1;
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (dut_vec !== mk(0, 0, 0)) begin
            errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, mk(0, 0, 0));
        end
        #1 RESET = 1'b0;
        m_out = 0; m_stk.delete(); m_err = 1'b0;
        drive(0, 4, 0, 0);
        checks++;
        if (dut_vec !== mk(1, 0, 1)) begin
            errors++; $display("FAIL ret_after_reset: got %h expected %h", dut_vec, mk(1, 0, 1));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            drive(($urandom_range(3) == 0), int'($urandom_range(7)),
                  $urandom_range((1 << AW) - 1), 1'($urandom_range(1)));
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL random%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_wrap();
        test_stall();
        test_call_ret();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
